// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory-port arbiter and its environment.
// Groups the instruction requester, data requester, shared memory port and
// the busy status line. The arbiter connects through the master modport
// (it masters the memory port and answers both requesters); the environment
// (requesters plus memory) connects through the slave modport.
interface mem_port_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned ERR_W  = 2;

    // instruction requester
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_rvalid;
    logic [DATA_W-1:0] inst_rdata;
    logic [ERR_W-1:0]  inst_err;

    // data requester
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [STRB_W-1:0] data_wstrb;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;
    logic [ERR_W-1:0]  data_err;

    // shared memory port
    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic [ERR_W-1:0]  mem_err;

    // status
    logic              busy;

    modport master (
        input  inst_req, inst_addr,
        output inst_rvalid, inst_rdata, inst_err,
        input  data_req, data_we, data_addr, data_wdata, data_wstrb,
        output data_rvalid, data_rdata, data_err,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, mem_err,
        output busy
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_rvalid, inst_rdata, inst_err,
        output data_req, data_we, data_addr, data_wdata, data_wstrb,
        input  data_rvalid, data_rdata, data_err,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, mem_err,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port.
// Ports: clk, rst (synchronous, active high) and bus (master modport of
// mem_port_arbiter_if: instruction/data request and response channels, the
// shared memory port, and busy).
// One access at a time: IDLE grants, BUSY holds the memory request until
// mem_ready or timeout, RESP pulses the owner's rvalid. Data normally wins,
// but an instruction request that has waited STARVE_LIMIT data grants wins.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned ERR_W  = 2;
    localparam int unsigned TO_W   = 8;
    localparam int unsigned ST_W   = 3;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic [ST_W-1:0]   starve_q, starve_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              owner_inst_q, owner_inst_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
    logic              inst_rvalid_q, inst_rvalid_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [ERR_W-1:0]  inst_err_q, inst_err_d;
    logic              data_rvalid_q, data_rvalid_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic [ERR_W-1:0]  data_err_q, data_err_d;
    logic              busy_q, busy_d;

    logic              inst_win, data_win;
    logic              rsp_done;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ERR_W-1:0]  rsp_err;

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        to_cnt_d      = to_cnt_q;
        owner_inst_d  = owner_inst_q;
        mem_valid_d   = mem_valid_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wstrb_d   = mem_wstrb_q;
        inst_rvalid_d = 1'b0;
        inst_rdata_d  = inst_rdata_q;
        inst_err_d    = inst_err_q;
        data_rvalid_d = 1'b0;
        data_rdata_d  = data_rdata_q;
        data_err_d    = data_err_q;
        rsp_done      = 1'b0;
        rsp_rdata     = '0;
        rsp_err       = '0;
        inst_win      = bus.inst_req &&
                        (!bus.data_req || starve_q == ST_W'(STARVE_LIMIT));
        data_win      = bus.data_req && !inst_win;

        case (state_q)
            IDLE: begin
                if (!bus.inst_req) begin
                    starve_d = '0;
                end
                if (inst_win) begin
                    state_d      = BUSY;
                    owner_inst_d = 1'b1;
                    mem_valid_d  = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = bus.inst_addr & 32'hFFFF_FFFC;
                    mem_wdata_d  = '0;
                    mem_wstrb_d  = '0;
                    to_cnt_d     = '0;
                    starve_d     = '0;
                end else if (data_win) begin
                    state_d      = BUSY;
                    owner_inst_d = 1'b0;
                    mem_valid_d  = 1'b1;
                    mem_we_d     = bus.data_we;
                    mem_addr_d   = bus.data_addr & 32'hFFFF_FFFC;
                    mem_wdata_d  = bus.data_wdata;
                    mem_wstrb_d  = bus.data_wstrb;
                    to_cnt_d     = '0;
                    if (bus.inst_req && starve_q != ST_W'(STARVE_LIMIT)) begin
                        starve_d = starve_q + ST_W'(1);
                    end
                end
            end
            BUSY: begin
                // mem_ready wins over a timeout landing in the same cycle
                if (bus.mem_ready) begin
                    rsp_done  = 1'b1;
                    rsp_rdata = mem_we_q ? '0 : bus.mem_rdata;
                    rsp_err   = bus.mem_err;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    rsp_done  = 1'b1;
                    rsp_rdata = '0;
                    rsp_err   = 2'b11;
                end else begin
                    to_cnt_d  = to_cnt_q + TO_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion: release the port and load the owner's response.
        if (rsp_done) begin
            state_d     = RESP;
            mem_valid_d = 1'b0;
            if (owner_inst_q) begin
                inst_rvalid_d = 1'b1;
                inst_rdata_d  = rsp_rdata;
                inst_err_d    = rsp_err;
            end else begin
                data_rvalid_d = 1'b1;
                data_rdata_d  = rsp_rdata;
                data_err_d    = rsp_err;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            starve_q      <= '0;
            to_cnt_q      <= '0;
            owner_inst_q  <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wstrb_q   <= '0;
            inst_rvalid_q <= 1'b0;
            inst_rdata_q  <= '0;
            inst_err_q    <= '0;
            data_rvalid_q <= 1'b0;
            data_rdata_q  <= '0;
            data_err_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            to_cnt_q      <= to_cnt_d;
            owner_inst_q  <= owner_inst_d;
            mem_valid_q   <= mem_valid_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wstrb_q   <= mem_wstrb_d;
            inst_rvalid_q <= inst_rvalid_d;
            inst_rdata_q  <= inst_rdata_d;
            inst_err_q    <= inst_err_d;
            data_rvalid_q <= data_rvalid_d;
            data_rdata_q  <= data_rdata_d;
            data_err_q    <= data_err_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.mem_valid   = mem_valid_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_wstrb   = mem_wstrb_q;
    assign bus.inst_rvalid = inst_rvalid_q;
    assign bus.inst_rdata  = inst_rdata_q;
    assign bus.inst_err    = inst_err_q;
    assign bus.data_rvalid = data_rvalid_q;
    assign bus.data_rdata  = data_rdata_q;
    assign bus.data_err    = data_err_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT=8, STARVE_LIMIT=2).
// Expected responses are queued when a request is driven and compared by a
// monitor whenever an rvalid pulse appears; grants are logged by address.
module tb_mem_port_arbiter;
    typedef struct {
        logic        is_inst;
        logic [31:0] rdata;
        logic [1:0]  err;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sb_entry_t   sb[$];
    logic [31:0] glog[$];
    sb_entry_t   e;
    logic        prev_valid = 1'b0;
    logic        prev_rv    = 1'b0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(8), .STARVE_LIMIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_inst, input logic [31:0] rdata, input logic [1:0] err);
        sb_entry_t x;
        x.is_inst = is_inst;
        x.rdata   = rdata;
        x.err     = err;
        sb.push_back(x);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Advance until any rvalid is seen or the budget expires; n = cycles taken.
    task automatic wait_rsp(input string tag, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.inst_rvalid || bus.data_rvalid) && n < max);
        chk({tag, "_rvalid"}, 64'(bus.inst_rvalid || bus.data_rvalid), 64'(1));
    endtask

    // Response scoreboard, pulse-width check and grant log.
    always @(negedge clk) begin
        if (bus.inst_rvalid || bus.data_rvalid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'(sb.size()), 64'(1));
            end else begin
                e = sb.pop_front();
                chk("rsp_owner", 64'(bus.inst_rvalid), 64'(e.is_inst));
                chk("rsp_both", 64'(bus.inst_rvalid && bus.data_rvalid), 64'(0));
                chk("rsp_rdata", 64'(e.is_inst ? bus.inst_rdata : bus.data_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(e.is_inst ? bus.inst_err : bus.data_err), 64'(e.err));
            end
        end
        if (prev_rv) begin
            chk("rvalid_pulse", 64'(bus.inst_rvalid || bus.data_rvalid), 64'(0));
        end
        if (bus.mem_valid && !prev_valid) begin
            glog.push_back(bus.mem_addr);
        end
        prev_rv    = bus.inst_rvalid || bus.data_rvalid;
        prev_valid = bus.mem_valid;
    end

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: observed timeout expected $finish");
    end

    initial begin
        int n;
        int vc;
        logic [31:0] exp_g[6];

        bus.inst_req   = 1'b0;
        bus.inst_addr  = '0;
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        bus.data_wstrb = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_err    = '0;

        // Reset state
        step();
        step();
        chk("rst_mem_valid", 64'(bus.mem_valid), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_rvalid", 64'({bus.inst_rvalid, bus.data_rvalid}), 64'(0));
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        rst = 1'b0;

        // Single inst read, mem_ready already high in IDLE (ignored there)
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_1003;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        bus.mem_err   = 2'b00;
        push(1'b1, 32'hDEAD_BEEF, 2'b00);
        step();
        chk("t1_mem_valid", 64'(bus.mem_valid), 64'(1));
        chk("t1_mem_addr", 64'(bus.mem_addr), 64'(32'h0000_1000));
        chk("t1_mem_we", 64'(bus.mem_we), 64'(0));
        chk("t1_mem_wstrb", 64'(bus.mem_wstrb), 64'(0));
        chk("t1_busy", 64'(bus.busy), 64'(1));
        wait_rsp("t1", 5, n);
        chk("t1_latency", 64'(n), 64'(1));
        bus.inst_req  = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        chk("t1_idle_busy", 64'(bus.busy), 64'(0));

        // Data write, mem_ready on the 4th mem_valid cycle
        bus.data_req   = 1'b1;
        bus.data_we    = 1'b1;
        bus.data_addr  = 32'h0000_0040;
        bus.data_wdata = 32'h1234_5678;
        bus.data_wstrb = 4'b0011;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        bus.mem_err    = 2'b10;
        push(1'b0, 32'h0, 2'b10);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_mem_valid", 64'(bus.mem_valid), 64'(1));
            chk("t2_mem_hold", 64'({bus.mem_we, bus.mem_wstrb, bus.mem_addr}),
                {27'd0, 1'b1, 4'b0011, 32'h0000_0040});
            chk("t2_mem_wdata", 64'(bus.mem_wdata), 64'(32'h1234_5678));
        end
        bus.mem_ready = 1'b1;
        wait_rsp("t2", 5, n);
        chk("t2_latency", 64'(n), 64'(1));
        chk("t2_valid_drop", 64'(bus.mem_valid), 64'(0));
        chk("t2_inst_hold", 64'(bus.inst_rdata), 64'(32'hDEAD_BEEF));
        bus.data_req  = 1'b0;
        bus.mem_ready = 1'b0;
        step();

        // Inst read with mem_err=01
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_2000;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hA5A5_A5A5;
        bus.mem_err   = 2'b01;
        push(1'b1, 32'hA5A5_A5A5, 2'b01);
        wait_rsp("t3", 6, n);
        bus.inst_req  = 1'b0;
        step();

        // Both requests held high: order D,D,I,D,D,I, 3-cycle turnaround
        glog.delete();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_3000;
        bus.data_req  = 1'b1;
        bus.data_we   = 1'b0;
        bus.data_addr = 32'h0000_4000;
        bus.mem_rdata = 32'h1111_1111;
        bus.mem_err   = 2'b00;
        exp_g = '{32'h4000, 32'h4000, 32'h3000, 32'h4000, 32'h4000, 32'h3000};
        for (int i = 0; i < 6; i++) begin
            push(exp_g[i] == 32'h3000, 32'h1111_1111, 2'b00);
        end
        for (int i = 0; i < 6; i++) begin
            wait_rsp("t4", 6, n);
            chk("t4_turnaround", 64'(n), 64'((i == 0) ? 2 : 3));
        end
        bus.inst_req  = 1'b0;
        bus.data_req  = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        chk("t4_grant_count", 64'(glog.size()), 64'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < glog.size()) chk("t4_grant_order", 64'(glog[i]), 64'(exp_g[i]));
        end

        // Timeout: mem_ready never asserted
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h0000_0050;
        bus.mem_rdata = 32'hCAFE_F00D;
        bus.mem_err   = 2'b00;
        push(1'b0, 32'h0, 2'b11);
        vc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!bus.mem_valid) break;
            vc++;
        end
        chk("t5_valid_cycles", 64'(vc), 64'(8));
        chk("t5_rvalid", 64'(bus.data_rvalid), 64'(1));
        bus.data_req = 1'b0;
        step();
        chk("t5_busy_after", 64'(bus.busy), 64'(0));

        // mem_ready in the last allowed cycle completes normally
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h0000_0060;
        bus.mem_rdata = 32'h0BAD_CAFE;
        push(1'b0, 32'h0BAD_CAFE, 2'b00);
        for (int i = 0; i < 8; i++) step();
        chk("t6_still_valid", 64'(bus.mem_valid), 64'(1));
        bus.mem_ready = 1'b1;
        wait_rsp("t6", 4, n);
        chk("t6_latency", 64'(n), 64'(1));
        bus.data_req  = 1'b0;
        bus.mem_ready = 1'b0;
        step();

        // Reset in mid-BUSY, request re-granted right after
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_7000;
        bus.mem_rdata = 32'h7777_0000;
        step();
        step();
        chk("t7_pre_valid", 64'(bus.mem_valid), 64'(1));
        rst = 1'b1;
        step();
        chk("t7_rst_valid", 64'(bus.mem_valid), 64'(0));
        chk("t7_rst_busy", 64'(bus.busy), 64'(0));
        chk("t7_rst_rdata", 64'(bus.inst_rdata), 64'(0));
        rst = 1'b0;
        step();
        chk("t7_regrant", 64'(bus.mem_valid), 64'(1));
        chk("t7_regrant_addr", 64'(bus.mem_addr), 64'(32'h0000_7000));
        bus.mem_ready = 1'b1;
        push(1'b1, 32'h7777_0000, 2'b00);
        wait_rsp("t7", 4, n);
        chk("t7_latency", 64'(n), 64'(1));
        bus.inst_req  = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        step();

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: TIMEOUT, 255, memory cycles allowed before abort (1..255); STARVE_LIMIT, 2, consecutive data grants allowed while an instruction request waits (1..7).
REQ-002 Clock and reset ports SHALL be: clk  in  1  single clock, all state on rising edge; rst  in  1  synchronous active-high reset.
REQ-003 Instruction requester ports SHALL be: inst_req in 1 request level; inst_addr in 32 byte address; inst_rvalid out 1 response pulse; inst_rdata out 32 read data; inst_err out 2 response status.
REQ-004 Data requester ports SHALL be: data_req in 1; data_we in 1 write=1; data_addr in 32; data_wdata in 32; data_wstrb in 4 byte enables; data_rvalid out 1; data_rdata out 32; data_err out 2.
REQ-005 Memory port SHALL be: mem_valid out 1; mem_we out 1; mem_addr out 32; mem_wdata out 32; mem_wstrb out 4; mem_ready in 1 completion; mem_rdata in 32; mem_err in 2.
REQ-006 Status port SHALL be: busy out 1, high in every state except IDLE.

Function
REQ-007 The block SHALL implement states IDLE, BUSY and RESP.
REQ-008 In IDLE with no request pending, the block SHALL remain in IDLE with mem_valid=0.
REQ-009 In IDLE with a request pending, the block SHALL latch the winner's address, we, wdata and wstrb and enter BUSY; mem_valid SHALL rise the following cycle (one-cycle grant latency).
REQ-010 Instruction transactions SHALL drive mem_we=0 and mem_wstrb=4'b0000.
REQ-011 mem_addr SHALL equal the latched address with bits [1:0] forced to 2'b00.
REQ-012 With both requests pending, data SHALL win unless starve_cnt equals STARVE_LIMIT, in which case instruction SHALL win.
REQ-013 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on a data grant while inst_req=1, and SHALL clear on an instruction grant or on any IDLE cycle with inst_req=0.
REQ-014 In BUSY, mem_valid and all mem_* outputs SHALL be held stable until mem_ready=1 or timeout.
REQ-015 On mem_ready=1 in BUSY, the block SHALL register mem_rdata (zero for writes) and mem_err, drop mem_valid and enter RESP.
REQ-016 In RESP, exactly one of inst_rvalid/data_rvalid SHALL pulse for one cycle with the registered rdata/err; the block SHALL then return to IDLE without granting in the RESP cycle.
REQ-017 Requesters hold req and their request fields until rvalid and deassert req the cycle after rvalid; req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-018 Minimum per-access turnaround SHALL be 3 cycles (IDLE grant, BUSY with immediate mem_ready, RESP).
REQ-019 A timeout counter SHALL count BUSY cycles with mem_ready=0; on reaching TIMEOUT, the block SHALL drop mem_valid, enter RESP, and report err=2'b11 with rdata=0.
REQ-020 mem_ready arriving in the same cycle the count reaches TIMEOUT SHALL take priority, completing normally.
REQ-021 inst_rdata/data_rdata/err SHALL hold their values between pulses, and SHALL only be meaningful while the matching rvalid is high.
REQ-022 mem_ready while not in BUSY SHALL be ignored.

Reset
REQ-023 While rst=1 at a clock edge, state SHALL become IDLE, starve_cnt and the timeout counter SHALL become 0, and every output SHALL become 0.
REQ-024 Reset during BUSY or RESP SHALL abandon the transaction with no rvalid pulse; mem_valid SHALL be 0 from the first reset edge.
REQ-025 A request present in the first cycle after rst deasserts SHALL be granted in that cycle.

Verification
REQ-026 Single inst read, inst_addr=0x0000_1003, mem_ready=1 on the first mem_valid cycle with mem_rdata=0xDEADBEEF -> mem_addr=0x0000_1000, mem_we=0, inst_rvalid one cycle later with inst_rdata=0xDEADBEEF, inst_err=0.
REQ-027 Data write, addr=0x40, wdata=0x1234_5678, wstrb=4'b0011, mem_ready after 4 cycles -> mem outputs stable for all 4 cycles, then data_rvalid pulse with data_rdata=0 and data_err=mem_err.
REQ-028 inst_req and data_req held continuously high, STARVE_LIMIT=2 -> grant order D,D,I,D,D,I.
REQ-029 mem_ready never asserted, TIMEOUT=8 -> mem_valid high exactly 8 cycles, then requester rvalid with err=2'b11 and rdata=0, busy low the cycle after.
REQ-030 rst pulsed for one cycle in mid-BUSY -> mem_valid=0 and busy=0 at the next edge, no rvalid, and a pending request is re-granted in the first post-reset cycle.
REQ-031 mem_err=2'b01 with mem_ready on an inst read -> inst_err=2'b01 on the rvalid pulse, and starve_cnt=0 afterwards.
